// File: rtl/plic_agent_pkg.sv
// Shared definitions for the PLIC claim/complete agent: FSM state encoding
// and the claim/complete register location within the PLIC map.
package plic_agent_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLAIM,
      ST_DISPATCH,
      ST_SERVICE,
      ST_COMPLETE
   } agent_state_e;

   localparam logic [31:0] CLAIM_OFFSET = 32'h0020_0004;
   localparam logic [31:0] CLAIM_STRIDE = 32'h0000_1000;

   // Claim and complete share one register per target context.
   function automatic logic [31:0] claim_addr(input logic [31:0] base,
                                              input int unsigned target);
      return base + CLAIM_OFFSET + 32'(target) * CLAIM_STRIDE;
   endfunction

endpackage

// File: rtl/reg_intf.sv
// Register-bus request/response types shared across the PLIC slice.
// Request: addr, write, wdata, wstrb, valid (initiator drives).
// Response: rdata, error, ready (target drives; ready completes the transfer).
package reg_intf;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_intf_req_a32_d32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_agent.sv
// PLIC claim agent: when the PLIC signals a pending external interrupt,
// reads the claim register, hands the claimed ID to a handler, waits for
// the handler to finish, then writes the ID back to complete it. Only one
// ID is ever outstanding. A bus error parks the agent until reset.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   eip_i                external interrupt pending for TARGET_ID
//   req_o / resp_i       register-bus initiator to the PLIC
//   irq_valid_o/irq_id_o/irq_ready_i  claimed-ID handoff to the handler
//   done_i               handler finished (pulse, honoured in SERVICE only)
//   busy_o, err_o        not-idle, sticky bus error
//   spurious_cnt_o       saturating count of claims that returned ID 0
//
// Build option: define PLIC_CLAIM_AGENT_TIMEOUT_EN to add a bus watchdog
// that abandons a transfer after TIMEOUT unanswered cycles and flags err_o.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for eip_i (blocked while err_o)
// CLAIM    | bus read of the claim register
// DISPATCH | presenting the claimed ID to the handler
// SERVICE  | handler running, waiting for done_i
// COMPLETE | bus write of the ID to the complete register
module plic_claim_agent
   import plic_agent_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
   parameter int unsigned TARGET_ID = 0,
   parameter int unsigned SRCW      = 5,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         eip_i,
   output reg_intf::reg_intf_req_a32_d32 req_o,
   input  reg_intf::reg_intf_resp_d32    resp_i,
   output logic                         irq_valid_o,
   output logic [SRCW-1:0]              irq_id_o,
   input  logic                         irq_ready_i,
   input  logic                         done_i,
   output logic                         busy_o,
   output logic                         err_o,
   output logic [7:0]                   spurious_cnt_o
);

   localparam logic [31:0] CLAIM_ADDR = claim_addr(BASE_ADDR, TARGET_ID);

   agent_state_e    state_q, state_d;
   logic [SRCW-1:0] id_q;
   logic            err_q;
   logic [7:0]      spur_cnt_q;

   logic [SRCW-1:0] claim_id;
   logic            bus_state;
   logic            timeout_hit;
   logic            bus_err;
   logic            claim_ok;
   logic            spurious;

   assign claim_id  = resp_i.rdata[SRCW-1:0];
   assign bus_state = (state_q == ST_CLAIM) || (state_q == ST_COMPLETE);
   assign bus_err   = bus_state && ((resp_i.ready && resp_i.error) || timeout_hit);
   assign claim_ok  = (state_q == ST_CLAIM) && resp_i.ready && !resp_i.error;
   assign spurious  = claim_ok && (claim_id == '0);

   logic unused_rdata;
   assign unused_rdata = ^resp_i.rdata[31:SRCW];

`ifdef PLIC_CLAIM_AGENT_TIMEOUT_EN
   localparam logic [7:0] WD_LOAD = 8'(TIMEOUT - 1);

   // Down-counter reloaded on every state change; terminal count on the
   // TIMEOUT-th consecutive unanswered cycle of a transfer.
   logic [7:0] wd_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q <= '0;
      end else if (state_d != state_q) begin
         wd_q <= WD_LOAD;
      end else if (bus_state && !resp_i.ready && (wd_q != 8'd0)) begin
         wd_q <= wd_q - 8'd1;
      end
   end

   assign timeout_hit = bus_state && !resp_i.ready && (wd_q == 8'd0);
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (eip_i && !err_q) state_d = ST_CLAIM;
         end
         ST_CLAIM: begin
            if (bus_err)           state_d = ST_IDLE;
            else if (resp_i.ready) state_d = (claim_id == '0) ? ST_IDLE : ST_DISPATCH;
         end
         ST_DISPATCH: begin
            if (irq_ready_i) state_d = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (done_i) state_d = ST_COMPLETE;
         end
         ST_COMPLETE: begin
            if (bus_err || resp_i.ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_o       = '0;
      irq_valid_o = 1'b0;
      busy_o      = (state_q != ST_IDLE);
      case (state_q)
         ST_CLAIM: begin
            req_o.valid = 1'b1;
            req_o.addr  = CLAIM_ADDR;
         end
         ST_DISPATCH: begin
            irq_valid_o = 1'b1;
         end
         ST_COMPLETE: begin
            req_o.valid = 1'b1;
            req_o.write = 1'b1;
            req_o.addr  = CLAIM_ADDR;
            req_o.wdata = 32'(id_q);
            req_o.wstrb = 4'hF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q       <= '0;
         err_q      <= 1'b0;
         spur_cnt_q <= '0;
      end else begin
         if (claim_ok)                        id_q       <= claim_id;
         if (bus_err)                         err_q      <= 1'b1;
         if (spurious && (spur_cnt_q != 8'hFF)) spur_cnt_q <= spur_cnt_q + 8'd1;
      end
   end

   assign irq_id_o       = id_q;
   assign err_o          = err_q;
   assign spurious_cnt_o = spur_cnt_q;

endmodule

// File: tb/tb_plic_claim_agent.sv
// Bench for plic_claim_agent: a bus responder model answers claim reads
// from a queue of IDs, expected bus transfers and ID handoffs are queued
// by the stimulus and checked by an independent monitor.
module tb_plic_claim_agent;

   localparam logic [31:0] CLAIM_A = 32'h0C20_0004;

   logic                          clk_i = 1'b0;
   logic                          rst_ni;
   logic                          eip_i;
   reg_intf::reg_intf_req_a32_d32 req_o;
   reg_intf::reg_intf_resp_d32    resp_i;
   logic                          irq_valid_o;
   logic [4:0]                    irq_id_o;
   logic                          irq_ready_i;
   logic                          done_i;
   logic                          busy_o;
   logic                          err_o;
   logic [7:0]                    spurious_cnt_o;

   always #5 clk_i = ~clk_i;

   plic_claim_agent #(
      .BASE_ADDR (32'h0C00_0000),
      .TARGET_ID (0),
      .SRCW      (5),
      .TIMEOUT   (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .eip_i          (eip_i),
      .req_o          (req_o),
      .resp_i         (resp_i),
      .irq_valid_o    (irq_valid_o),
      .irq_id_o       (irq_id_o),
      .irq_ready_i    (irq_ready_i),
      .done_i         (done_i),
      .busy_o         (busy_o),
      .err_o          (err_o),
      .spurious_cnt_o (spurious_cnt_o)
   );

   typedef struct {
      bit          is_irq;
      logic [31:0] addr;
      bit          write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [4:0]  id;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] claim_q[$];
   bit          resp_en    = 1'b1;
   int          resp_delay = 0;
   bit          resp_err   = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic exp_read();
      exp_t e;
      e = '{is_irq: 1'b0, addr: CLAIM_A, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, id: 5'h0};
      exp_q.push_back(e);
   endtask

   task automatic exp_write(input logic [31:0] wd);
      exp_t e;
      e = '{is_irq: 1'b0, addr: CLAIM_A, write: 1'b1, wdata: wd, wstrb: 4'hF, id: 5'h0};
      exp_q.push_back(e);
   endtask

   task automatic exp_irq(input logic [4:0] id);
      exp_t e;
      e = '{is_irq: 1'b1, addr: 32'h0, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, id: id};
      exp_q.push_back(e);
   endtask

   // Bus target model: decides ready shortly after each rising edge.
   initial begin
      int waited;
      waited = 0;
      resp_i = '0;
      forever begin
         @(posedge clk_i);
         #2;
         if (req_o.valid && resp_en) begin
            if (waited >= resp_delay) begin
               resp_i.ready = 1'b1;
               resp_i.error = resp_err;
               if (!req_o.write && claim_q.size() > 0) resp_i.rdata = claim_q.pop_front();
               else                                    resp_i.rdata = 32'h0;
               waited = 0;
            end else begin
               resp_i = '0;
               waited++;
            end
         end else begin
            resp_i = '0;
            waited = 0;
         end
      end
   end

   // Monitor: checks every completed bus transfer and ID handoff.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         chk("exclusive", 32'(irq_valid_o & req_o.valid), 32'h0);
         if (!req_o.valid) chk("req_zero_when_idle", 32'(req_o != '0), 32'h0);
         if (rst_ni && req_o.valid && resp_i.ready) begin
            if (exp_q.size() == 0) chk("unexpected_bus", 32'h1, 32'h0);
            else begin
               e = exp_q.pop_front();
               chk("kind_bus", 32'(e.is_irq), 32'h0);
               chk("bus_addr", req_o.addr, e.addr);
               chk("bus_write", 32'(req_o.write), 32'(e.write));
               chk("bus_wdata", req_o.wdata, e.wdata);
               chk("bus_wstrb", 32'(req_o.wstrb), 32'(e.wstrb));
            end
         end
         if (rst_ni && irq_valid_o && irq_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_irq", 32'h1, 32'h0);
            else begin
               e = exp_q.pop_front();
               chk("kind_irq", 32'(e.is_irq), 32'h1);
               chk("irq_id", 32'(irq_id_o), 32'(e.id));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_o && n < 50) begin
         tick();
         n++;
      end
      if (busy_o) chk(name, 32'h1, 32'h0);
   endtask

   // Raises eip for one claim and returns cycles until irq_valid_o.
   task automatic claim_to_dispatch(output int cycles);
      eip_i  = 1'b1;
      cycles = 0;
      while (!irq_valid_o && cycles < 50) begin
         tick();
         cycles++;
         if (busy_o) eip_i = 1'b0;
      end
      eip_i = 1'b0;
      if (!irq_valid_o) chk("dispatch_timeout", 32'h1, 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(req_o != '0), 32'h0);
      chk({tag, "_irq_valid"}, 32'(irq_valid_o), 32'h0);
      chk({tag, "_irq_id"}, 32'(irq_id_o), 32'h0);
      chk({tag, "_busy"}, 32'(busy_o), 32'h0);
      chk({tag, "_err"}, 32'(err_o), 32'h0);
      chk({tag, "_spur"}, 32'(spurious_cnt_o), 32'h0);
   endtask

   initial begin
      int cyc;
      rst_ni      = 1'b0;
      eip_i       = 1'b0;
      irq_ready_i = 1'b0;
      done_i      = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      tick();

      // done_i while idle is ignored
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      tick();
      chk("done_in_idle_busy", 32'(busy_o), 32'h0);

      // basic claim of ID 7, two-cycle latency, completion write of 7
      claim_q.push_back(32'd7);
      exp_read();
      exp_irq(5'd7);
      exp_write(32'd7);
      claim_to_dispatch(cyc);
      chk("latency", 32'(cyc), 32'd2);
      chk("id7", 32'(irq_id_o), 32'd7);
      irq_ready_i = 1'b1;
      tick();
      irq_ready_i = 1'b0;
      chk("service_no_irq", 32'(irq_valid_o), 32'h0);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      wait_idle("idle_after_id7");

      // three spurious claims
      for (int k = 0; k < 3; k++) begin
         claim_q.push_back(32'd0);
         exp_read();
         eip_i = 1'b1;
         tick();
         eip_i = 1'b0;
         wait_idle("idle_after_spurious");
      end
      chk("spurious_cnt", 32'(spurious_cnt_o), 32'd3);
      chk("spurious_busy", 32'(busy_o), 32'h0);
      chk("spurious_no_irq", 32'(irq_valid_o), 32'h0);

      // ID from upper-garbage rdata, handler stalls 10 cycles, slow completion
      claim_q.push_back(32'hFFFF_FF1F);
      exp_read();
      exp_irq(5'd31);
      exp_write(32'h0000_001F);
      claim_to_dispatch(cyc);
      for (int i = 0; i < 10; i++) begin
         done_i = (i == 4);
         tick();
         chk("stall_valid", 32'(irq_valid_o), 32'h1);
         chk("stall_id", 32'(irq_id_o), 32'd31);
         chk("stall_no_bus", 32'(req_o.valid), 32'h0);
      end
      done_i      = 1'b0;
      irq_ready_i = 1'b1;
      tick();
      irq_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("service_wait_busy", 32'(busy_o), 32'h1);
         chk("service_wait_no_bus", 32'(req_o.valid), 32'h0);
      end
      resp_delay = 3;
      done_i     = 1'b1;
      tick();
      done_i = 1'b0;
      chk("complete_write", 32'(req_o.valid & req_o.write), 32'h1);
      wait_idle("idle_after_slow_complete");
      resp_delay = 0;

      // reset while the completion write is stalled
      claim_q.push_back(32'd3);
      exp_read();
      exp_irq(5'd3);
      claim_to_dispatch(cyc);
      irq_ready_i = 1'b1;
      tick();
      irq_ready_i = 1'b0;
      resp_en = 1'b0;
      done_i  = 1'b1;
      tick();
      done_i = 1'b0;
      tick();
      chk("stalled_write_valid", 32'(req_o.valid), 32'h1);
      chk("stalled_write_wdata", req_o.wdata, 32'd3);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      rst_ni  = 1'b1;
      resp_en = 1'b1;
      repeat (5) tick();
      chk("post_reset_busy", 32'(busy_o), 32'h0);
      chk("post_reset_queue", 32'(exp_q.size()), 32'h0);

`ifdef PLIC_CLAIM_AGENT_TIMEOUT_EN
      // watchdog: target never answers
      resp_en = 1'b0;
      eip_i   = 1'b1;
      tick();
      eip_i = 1'b0;
      cyc   = 0;
      while (req_o.valid && cyc < 20) begin
         cyc++;
         tick();
      end
      chk("timeout_wait_cycles", 32'(cyc), 32'd4);
      chk("timeout_err", 32'(err_o), 32'h1);
      chk("timeout_valid", 32'(req_o.valid), 32'h0);
      chk("timeout_busy", 32'(busy_o), 32'h0);
      rst_ni = 1'b0;
      tick();
      rst_ni  = 1'b1;
      resp_en = 1'b1;
      tick();
`endif

      // bus error on claim parks the agent
      resp_err = 1'b1;
      claim_q.push_back(32'd9);
      exp_read();
      eip_i = 1'b1;
      tick();
      eip_i = 1'b0;
      wait_idle("idle_after_error");
      resp_err = 1'b0;
      tick();
      chk("error_sticky", 32'(err_o), 32'h1);
      chk("error_no_irq", 32'(irq_valid_o), 32'h0);
      eip_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("error_blocks_claim", 32'(req_o.valid), 32'h0);
         chk("error_stays_idle", 32'(busy_o), 32'h0);
      end
      eip_i  = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("error_cleared_by_reset", 32'(err_o), 32'h0);
      tick();
      rst_ni = 1'b1;

      repeat (3) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/plic_claim_agent.md
PLIC_CLAIM_AGENT -- requirements
Module: plic_claim_agent

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0C00_0000, PLIC base address.
REQ-002 SHALL have parameter TARGET_ID, default 0, PLIC target (context) index served.
REQ-003 SHALL have parameter SRCW, default 5, interrupt-ID width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum bus-wait cycles (used only under REQ-030).
REQ-005 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port eip_i, input, 1, external interrupt pending from the PLIC for TARGET_ID.
REQ-008 SHALL have port req_o, output, reg_intf::reg_intf_req_a32_d32, register-bus request to the PLIC (initiator side).
REQ-009 SHALL have port resp_i, input, reg_intf::reg_intf_resp_d32, register-bus response from the PLIC.
REQ-010 SHALL have ports irq_valid_o (output, 1), irq_id_o (output, SRCW), irq_ready_i (input, 1): claimed-ID handoff to the handler.
REQ-011 SHALL have port done_i, input, 1, single-cycle pulse: handler finished the dispatched ID.
REQ-012 SHALL have ports busy_o (output, 1, FSM not IDLE), err_o (output, 1, sticky bus error), spurious_cnt_o (output, 8, saturating count of zero claims).

Function
REQ-013 Claim/complete address SHALL be BASE_ADDR + 32'h20_0004 + TARGET_ID*32'h1000.
REQ-014 FSM states SHALL be IDLE, CLAIM, DISPATCH, SERVICE, COMPLETE.
REQ-015 IDLE->CLAIM when eip_i==1 and err_o==0; eip_i sampled only in IDLE.
REQ-016 In CLAIM: req_o.valid=1, write=0, addr per REQ-013, wstrb=0; valid held stable until resp_i.ready.
REQ-017 On CLAIM with resp_i.ready and !resp_i.error: ID=rdata[SRCW-1:0]; ID!=0 -> DISPATCH; ID==0 -> IDLE and spurious_cnt_o+=1, saturating at 255.
REQ-018 In DISPATCH: irq_valid_o=1, irq_id_o=ID; both stable until irq_ready_i; handshake cycle -> SERVICE.
REQ-019 In SERVICE: wait for done_i -> COMPLETE; done_i outside SERVICE SHALL be ignored.
REQ-020 In COMPLETE: req_o.valid=1, write=1, addr per REQ-013, wdata={zero-extended ID}, wstrb=4'hF; resp_i.ready -> IDLE.
REQ-021 resp_i.error on any accepted transfer SHALL set err_o and return to IDLE; err_o clears only on reset; no further claims while err_o.
REQ-022 req_o.valid SHALL be 0 in IDLE, DISPATCH, SERVICE; req_o fields SHALL be 0 whenever valid==0.
REQ-023 Minimum latency eip_i rise -> irq_valid_o SHALL be 2 cycles given same-cycle resp_i.ready.
REQ-024 irq_valid_o and req_o.valid SHALL never be asserted in the same cycle.
REQ-025 A new claim SHALL not start until the previous COMPLETE write is acknowledged (one outstanding ID).

Reset
REQ-026 On rst_ni low: state=IDLE, req_o='0, irq_valid_o=0, irq_id_o=0, busy_o=0, err_o=0, spurious_cnt_o=0, stored ID=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer immediately with no completion write.
REQ-028 After reset release, first claim no earlier than the first rising edge with eip_i==1.

Configuration
REQ-029 Macro PLIC_CLAIM_AGENT_TIMEOUT_EN SHALL control a bus watchdog.
REQ-030 Defined: 8-bit counter runs in CLAIM/COMPLETE while !resp_i.ready, cleared on state entry; reaching TIMEOUT drops req_o.valid, sets err_o, returns to IDLE.
REQ-031 Not defined: no counter; agent waits indefinitely for resp_i.ready.

Structure
REQ-032 A shared package plic_agent_pkg SHALL hold the state enum and claim-offset constants (32'h20_0004, stride 32'h1000).
REQ-033 The design SHALL be a single module with no sub-modules.

Verification
REQ-034 eip_i=1, PLIC returns 7, ready same cycle -> irq_valid_o with irq_id_o=7 two cycles later; done_i -> write data 7 to 0x0C20_0004 (TARGET_ID=0).
REQ-035 PLIC returns ID 0 three times -> no irq_valid_o, spurious_cnt_o=3, busy_o returns to 0.
REQ-036 irq_ready_i held low 10 cycles -> irq_valid_o/irq_id_o stable for all 10; no bus activity.
REQ-037 resp_i.error=1 on claim -> err_o=1; later eip_i=1 produces no req_o.valid until reset.
REQ-038 TIMEOUT_EN, TIMEOUT=4, ready never asserted -> err_o=1 after 4 wait cycles, req_o.valid=0.
REQ-039 rst_ni low during COMPLETE with ready low -> all outputs per REQ-026 immediately; no write observed.
